// File: rtl/asteroid_pkg.sv
// Shared constants and types for the asteroid game: screen geometry,
// coordinate/colour widths, palette entries and the render state encoding.
package asteroid_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [X_W-1:0] SCREEN_W = 8'd160;
  localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

  localparam logic [COLOUR_W-1:0] COLOUR_DRAW  = 3'b111;
  localparam logic [COLOUR_W-1:0] COLOUR_ERASE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } render_state_t;

endpackage

// File: rtl/block_pixel_walker.sv
// Walks a BLOCK x BLOCK square row-major (dx inner) from a base corner.
// The pixel outputs describe the pixel being emitted this cycle; asserting
// start forces that pixel to the corner and the counter then moves on.
module block_pixel_walker
  import asteroid_pkg::*;
#(
  parameter int BLOCK = 3
) (
  input  logic           game_clk,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           in_screen,
  output logic           last
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] END_IDX = CNT_W'(BLOCK - 1);

  logic [CNT_W-1:0] dx;
  logic [CNT_W-1:0] dy;
  logic [CNT_W-1:0] cur_dx;
  logic [CNT_W-1:0] cur_dy;
  logic [CNT_W-1:0] next_dx;
  logic [CNT_W-1:0] next_dy;

  // Current offset, its successor, and the wrapped on-screen pixel address
  always_comb begin
    cur_dx  = start ? '0 : dx;
    cur_dy  = start ? '0 : dy;
    last    = (cur_dx == END_IDX) && (cur_dy == END_IDX);
    next_dx = cur_dx + CNT_W'(1);
    next_dy = cur_dy;
    if (cur_dx == END_IDX) begin
      next_dx = '0;
      next_dy = last ? '0 : cur_dy + CNT_W'(1);
    end
    pix_x     = base_x + X_W'(cur_dx);
    pix_y     = base_y + Y_W'(cur_dy);
    in_screen = (pix_x < SCREEN_W) && (pix_y < SCREEN_H);
  end

  // Offset counter, stepping once per emitted pixel and wrapping after the last
  always_ff @(posedge game_clk) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= next_dx;
      dy <= next_dy;
    end
  end

endmodule

// File: rtl/asteroid_render_scheduler.sv
// Once per frame, walks all asteroid slots and drives the VGA plot port:
// erases each square drawn last frame if it moved or vanished, then draws
// the square at the snapshot position. Output pixels are registered, so the
// pixel chosen in a cycle is presented on the port in the following cycle.
module asteroid_render_scheduler
  import asteroid_pkg::*;
#(
  parameter int                  NUM_SLOTS    = 8,
  parameter int                  BLOCK        = 3,
  parameter logic [COLOUR_W-1:0] DRAW_COLOUR  = COLOUR_DRAW,
  parameter logic [COLOUR_W-1:0] ERASE_COLOUR = COLOUR_ERASE
) (
  input  logic                     game_clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [NUM_SLOTS-1:0]     active,
  input  logic [X_W*NUM_SLOTS-1:0] x_coords,
  input  logic [Y_W*NUM_SLOTS-1:0] y_coords,
  output logic                     plot,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COLOUR_W-1:0]      colour,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  render_state_t state;
  render_state_t next_state;

  logic [SLOT_W-1:0]    slot;
  logic [NUM_SLOTS-1:0] snap_active;
  logic [X_W-1:0]       snap_x [NUM_SLOTS];
  logic [Y_W-1:0]       snap_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] prev_valid;
  logic [X_W-1:0]       prev_x [NUM_SLOTS];
  logic [Y_W-1:0]       prev_y [NUM_SLOTS];
  logic                 pix_last;

  logic                cur_active;
  logic                need_erase;
  render_state_t       after_slot;
  logic                emit;
  logic                walk_start;
  logic                use_prev;
  logic [COLOUR_W-1:0] emit_colour;
  logic                take_snapshot;
  logic                advance_slot;
  logic                clear_valid;
  logic                commit_draw;
  logic [X_W-1:0]      walk_base_x;
  logic [Y_W-1:0]      walk_base_y;
  logic [X_W-1:0]      walk_x;
  logic [Y_W-1:0]      walk_y;
  logic                walk_in_screen;
  logic                walk_last;

  block_pixel_walker #(
    .BLOCK(BLOCK)
  ) u_walker (
    .game_clk (game_clk),
    .reset    (reset),
    .start    (walk_start),
    .base_x   (walk_base_x),
    .base_y   (walk_base_y),
    .pix_x    (walk_x),
    .pix_y    (walk_y),
    .in_screen(walk_in_screen),
    .last     (walk_last)
  );

  // Per-slot decision: an old square must go unless it is still active in place
  always_comb begin
    cur_active = snap_active[slot];
    need_erase = prev_valid[slot] &&
                 !(cur_active && (snap_x[slot] == prev_x[slot]) &&
                   (snap_y[slot] == prev_y[slot]));
    after_slot = (slot == LAST_SLOT) ? ST_DONE : ST_SCAN;
  end

  // State register
  always_ff @(posedge game_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; ERASE and DRAW end once their last pixel is on the port
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (frame_tick) next_state = ST_SCAN;
      ST_SCAN: begin
        if (need_erase)      next_state = ST_ERASE;
        else if (cur_active) next_state = ST_DRAW;
        else                 next_state = after_slot;
      end
      ST_ERASE: if (pix_last) next_state = cur_active ? ST_DRAW : after_slot;
      ST_DRAW:  if (pix_last) next_state = after_slot;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Control decode: which pixel to emit next and which bookkeeping to update
  always_comb begin
    emit          = 1'b0;
    walk_start    = 1'b0;
    use_prev      = 1'b0;
    emit_colour   = DRAW_COLOUR;
    take_snapshot = 1'b0;
    advance_slot  = 1'b0;
    clear_valid   = 1'b0;
    commit_draw   = 1'b0;
    case (state)
      ST_IDLE: take_snapshot = frame_tick;
      ST_SCAN: begin
        if (need_erase) begin
          emit        = 1'b1;
          walk_start  = 1'b1;
          use_prev    = 1'b1;
          emit_colour = ERASE_COLOUR;
        end else if (cur_active) begin
          emit       = 1'b1;
          walk_start = 1'b1;
        end else begin
          advance_slot = 1'b1;
        end
      end
      ST_ERASE: begin
        if (!pix_last) begin
          emit        = 1'b1;
          use_prev    = 1'b1;
          emit_colour = ERASE_COLOUR;
        end else if (cur_active) begin
          emit       = 1'b1;
          walk_start = 1'b1;
        end else begin
          clear_valid  = 1'b1;
          advance_slot = 1'b1;
        end
      end
      ST_DRAW: begin
        if (!pix_last) begin
          emit = 1'b1;
        end else begin
          commit_draw  = 1'b1;
          advance_slot = 1'b1;
        end
      end
      default: ;
    endcase
    walk_base_x = use_prev ? prev_x[slot] : snap_x[slot];
    walk_base_y = use_prev ? prev_y[slot] : snap_y[slot];
  end

  // Snapshot, slot pointer and record of what is currently on screen
  always_ff @(posedge game_clk) begin
    if (reset) begin
      slot        <= '0;
      snap_active <= '0;
      prev_valid  <= '0;
      pix_last    <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        snap_x[s] <= '0;
        snap_y[s] <= '0;
        prev_x[s] <= '0;
        prev_y[s] <= '0;
      end
    end else begin
      pix_last <= emit && walk_last;
      if (take_snapshot) begin
        slot        <= '0;
        snap_active <= active;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          snap_x[s] <= x_coords[X_W*s +: X_W];
          snap_y[s] <= y_coords[Y_W*s +: Y_W];
        end
      end
      if (advance_slot) slot <= slot + SLOT_W'(1);
      if (clear_valid) prev_valid[slot] <= 1'b0;
      if (commit_draw) begin
        prev_valid[slot] <= 1'b1;
        prev_x[slot]     <= snap_x[slot];
        prev_y[slot]     <= snap_y[slot];
      end
    end
  end

  // Registered port outputs; off-screen pixels spend their cycle with plot low
  always_ff @(posedge game_clk) begin
    if (reset) begin
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      colour     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      plot       <= emit && walk_in_screen;
      busy       <= (next_state != ST_IDLE);
      frame_done <= (next_state == ST_DONE);
      if (emit) begin
        vga_x  <= walk_x;
        vga_y  <= walk_y;
        colour <= emit_colour;
      end
    end
  end

  assign overrun = frame_tick && busy;

endmodule

// File: tb/tb_asteroid_render_scheduler.sv
// Directed bench for asteroid_render_scheduler. Each pass starts with the
// tick in cycle 0; every plotted pixel is recorded with its cycle number and
// compared against squares built from hand-chosen coordinates.
module tb_asteroid_render_scheduler;

  logic        game_clk;
  logic        reset;
  logic        frame_tick;
  logic [7:0]  active;
  logic [63:0] x_coords;
  logic [55:0] y_coords;
  logic        plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  colour;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int vectors;
  int miscompares;

  int got_px[$];
  int got_cyc[$];
  int exp_px[$];
  int busy_log[$];
  int done_cycle;
  int done_pulses;
  int overrun_cnt;
  int overrun_first;

  asteroid_render_scheduler dut (
    .game_clk  (game_clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .active    (active),
    .x_coords  (x_coords),
    .y_coords  (y_coords),
    .plot      (plot),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .colour    (colour),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  initial game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, actual, actual, expected, expected);
    end
  endtask

  function automatic int packPixel(input int x, input int y, input int c);
    return (x << 16) | (y << 8) | c;
  endfunction

  task automatic setSlot(input int s, input int x, input int y);
    x_coords[8*s +: 8] = 8'(x);
    y_coords[7*s +: 7] = 7'(y);
  endtask

  // Expected pixels of a 3x3 square, wrapped to the field widths, visible only
  task automatic addSquare(input int x0, input int y0, input int c);
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        int x;
        int y;
        x = (x0 + dx) & 255;
        y = (y0 + dy) & 127;
        if (x < 160 && y < 120) exp_px.push_back(packPixel(x, y, c));
      end
    end
  endtask

  function automatic int busyAt(input int i);
    return (i < busy_log.size()) ? busy_log[i] : -1;
  endfunction

  function automatic int firstPlot();
    return (got_cyc.size() > 0) ? got_cyc[0] : -1;
  endfunction

  function automatic int lastPlot();
    return (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : -1;
  endfunction

  // Runs one pass: tick in cycle 0, optional extra ticks, sampled mid-cycle
  task automatic applyStimulus(input int tick_a, input int tick_b);
    bit finished;
    got_px.delete();
    got_cyc.delete();
    busy_log.delete();
    done_cycle    = -1;
    done_pulses   = 0;
    overrun_cnt   = 0;
    overrun_first = -1;
    finished      = 0;
    for (int c = 0; c < 80 && !finished; c++) begin
      frame_tick = (c == 0) || (c == tick_a) || (c == tick_b);
      @(negedge game_clk);
      busy_log.push_back(int'(busy));
      if (plot) begin
        got_px.push_back(packPixel(int'(vga_x), int'(vga_y), int'(colour)));
        got_cyc.push_back(c);
      end
      if (frame_done) begin
        done_pulses++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (overrun) begin
        overrun_cnt++;
        if (overrun_first < 0) overrun_first = c;
      end
      if (done_cycle >= 0 && c >= done_cycle + 1 && c >= tick_a && c >= tick_b)
        finished = 1;
      @(posedge game_clk);
      #1;
    end
    frame_tick = 1'b0;
    if (!finished) checkOutput("pass_timeout", 0, 1);
  endtask

  task automatic checkPixels(input string tag);
    checkOutput({tag, "_plots"}, got_px.size(), exp_px.size());
    for (int i = 0; i < exp_px.size() && i < got_px.size(); i++)
      checkOutput($sformatf("%s_pix%0d", tag, i), got_px[i], exp_px[i]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    frame_tick  = 1'b0;
    active      = '0;
    x_coords    = '0;
    y_coords    = '0;

    $display("[TB] reset values");
    repeat (2) @(posedge game_clk);
    @(negedge game_clk);
    checkOutput("rst_plot", int'(plot), 0);
    checkOutput("rst_vga_x", int'(vga_x), 0);
    checkOutput("rst_vga_y", int'(vga_y), 0);
    checkOutput("rst_colour", int'(colour), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    @(posedge game_clk);
    #1;
    reset = 1'b0;
    @(posedge game_clk);
    #1;

    // Empty pass: 1 tick + 8 skipped slots + DONE, frame_done in cycle 9
    $display("[TB] empty pass");
    exp_px.delete();
    applyStimulus(-1, -1);
    checkPixels("empty");
    checkOutput("empty_busy_c0", busyAt(0), 0);
    checkOutput("empty_busy_c1", busyAt(1), 1);
    checkOutput("empty_busy_c9", busyAt(9), 1);
    checkOutput("empty_busy_c10", busyAt(10), 0);
    checkOutput("empty_done_cycle", done_cycle, 9);
    checkOutput("empty_done_pulses", done_pulses, 1);

    // Slot0 first draw at (10,20): plots in cycles 2..10, DONE at 1+1+10+7-1
    $display("[TB] first draw");
    active = 8'b0000_0001;
    setSlot(0, 10, 20);
    exp_px.delete();
    addSquare(10, 20, 7);
    applyStimulus(-1, -1);
    checkPixels("draw");
    checkOutput("draw_first_cycle", firstPlot(), 2);
    checkOutput("draw_last_cycle", lastPlot(), 10);
    checkOutput("draw_done_cycle", done_cycle, 18);

    // Slot0 moves to (11,20): erase 9 then draw 9 back to back, cycles 2..19
    $display("[TB] move");
    setSlot(0, 11, 20);
    exp_px.delete();
    addSquare(10, 20, 0);
    addSquare(11, 20, 7);
    applyStimulus(-1, -1);
    checkPixels("move");
    checkOutput("move_first_cycle", firstPlot(), 2);
    checkOutput("move_last_cycle", lastPlot(), 19);
    checkOutput("move_done_cycle", done_cycle, 27);

    // Slot0 deactivated: erase only; the following pass leaves it alone
    $display("[TB] deactivate");
    active = 8'b0000_0000;
    exp_px.delete();
    addSquare(11, 20, 0);
    applyStimulus(-1, -1);
    checkPixels("gone");
    checkOutput("gone_done_cycle", done_cycle, 18);
    exp_px.delete();
    applyStimulus(-1, -1);
    checkPixels("gone2");
    checkOutput("gone2_done_cycle", done_cycle, 9);

    // Slot1 at the screen corner: 9 walk cycles 3..11, only 4 visible pixels
    $display("[TB] clipping");
    active = 8'b0000_0010;
    setSlot(1, 158, 118);
    exp_px.delete();
    addSquare(158, 118, 7);
    applyStimulus(-1, -1);
    checkPixels("clip");
    checkOutput("clip_first_cycle", firstPlot(), 3);
    checkOutput("clip_last_cycle", lastPlot(), 7);
    checkOutput("clip_done_cycle", done_cycle, 18);

    // Unchanged slot is redrawn without erase; ticks mid-pass and in DONE are dropped
    $display("[TB] overrun");
    exp_px.delete();
    addSquare(158, 118, 7);
    applyStimulus(5, 18);
    checkPixels("ovr");
    checkOutput("ovr_count", overrun_cnt, 2);
    checkOutput("ovr_first_cycle", overrun_first, 5);
    checkOutput("ovr_done_cycle", done_cycle, 18);
    checkOutput("ovr_done_pulses", done_pulses, 1);
    checkOutput("ovr_busy_c19", busyAt(19), 0);

    // Reset during slot0 draw aborts at once and forgets what was on screen
    $display("[TB] reset mid-draw");
    active = 8'b0000_0001;
    setSlot(0, 50, 40);
    for (int c = 0; c < 8; c++) begin
      frame_tick = (c == 0);
      reset      = (c == 5);
      @(negedge game_clk);
      if (c == 4) begin
        checkOutput("abort_plot_c4", int'(plot), 1);
        checkOutput("abort_x_c4", int'(vga_x), 52);
      end
      if (c == 6) begin
        checkOutput("abort_plot_c6", int'(plot), 0);
        checkOutput("abort_busy_c6", int'(busy), 0);
      end
      @(posedge game_clk);
      #1;
    end
    reset      = 1'b0;
    frame_tick = 1'b0;
    exp_px.delete();
    addSquare(50, 40, 7);
    applyStimulus(-1, -1);
    checkPixels("redraw");
    checkOutput("redraw_first_cycle", firstPlot(), 2);
    checkOutput("redraw_done_cycle", done_cycle, 18);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
